// File: rtl/itch_frame_assembler.sv
// Collects 12 stream bytes and packs them big-endian into three 32-bit words for the parser.
// Optional frame checking (runt/oversize drop on i_last) is enabled by defining FRAME_CHECK_EN.
module itch_frame_assembler #(
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_ready,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic                 o_valid,
  output logic [CNT_WIDTH-1:0] o_msg_count,
  output logic [CNT_WIDTH-1:0] o_drop_count
);

  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EMIT    = 2'd1
`ifdef FRAME_CHECK_EN
    ,
    S_DISCARD = 2'd2
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           buf_q [12];
  logic [7:0]           buf_d [12];
  logic [REG_WIDTH-1:0] reg_1_q, reg_1_d;
  logic [REG_WIDTH-1:0] reg_2_q, reg_2_d;
  logic [REG_WIDTH-1:0] reg_3_q, reg_3_d;
  logic [CNT_WIDTH-1:0] msg_count_q, msg_count_d;
  logic [CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                 accept;

  assign o_ready      = !i_reset && (state_q != S_EMIT);
  assign accept       = i_valid && o_ready;
  assign o_valid      = (state_q == S_EMIT);
  assign o_reg_1      = reg_1_q;
  assign o_reg_2      = reg_2_q;
  assign o_reg_3      = reg_3_q;
  assign o_msg_count  = msg_count_q;
  assign o_drop_count = drop_count_q;

`ifdef FRAME_CHECK_EN
  logic [CNT_WIDTH-1:0] drop_count_sat;
  assign drop_count_sat = (drop_count_q == '1) ? drop_count_q
                                               : drop_count_q + CNT_WIDTH'(1);
`else
  logic unused_last;
  assign unused_last = i_last;
`endif

  // NOTE: every variable gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    reg_1_d      = reg_1_q;
    reg_2_d      = reg_2_q;
    reg_3_d      = reg_3_q;
    msg_count_d  = msg_count_q;
    drop_count_d = drop_count_q;

    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef FRAME_CHECK_EN
            if (!i_last) begin
              drop_count_d = drop_count_sat;
              state_d      = S_DISCARD;
            end else
`endif
            begin
              // The final byte bypasses the buffer so the words load on the accepting edge.
              reg_1_d = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
              reg_2_d = {buf_q[4], buf_q[5], buf_q[6], buf_q[7]};
              reg_3_d = {buf_q[8], buf_q[9], buf_q[10], i_data};
              state_d = S_EMIT;
            end
          end
`ifdef FRAME_CHECK_EN
          else if (i_last) begin
            drop_count_d = drop_count_sat;
            idx_d        = '0;
          end
`endif
          else begin
            buf_d[idx_q] = i_data;
            idx_d        = idx_q + 4'd1;
          end
        end
      end
      S_EMIT: begin
        msg_count_d = msg_count_q + CNT_WIDTH'(1);
        state_d     = S_COLLECT;
      end
`ifdef FRAME_CHECK_EN
      S_DISCARD: begin
        if (accept && i_last) begin
          idx_d   = '0;
          state_d = S_COLLECT;
        end
      end
`endif
      default: begin
        idx_d   = '0;
        state_d = S_COLLECT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_COLLECT;
      idx_q        <= '0;
      reg_1_q      <= '0;
      reg_2_q      <= '0;
      reg_3_q      <= '0;
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      reg_1_q      <= reg_1_d;
      reg_2_q      <= reg_2_d;
      reg_3_q      <= reg_3_d;
      msg_count_q  <= msg_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // NOTE: the byte buffer is not reset; idx returns to 0 and every slot is rewritten before it is read.
  always_ff @(posedge i_clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_itch_frame_assembler.sv
// Directed self-checking bench for itch_frame_assembler; frame-check cases run when FRAME_CHECK_EN is defined.
module tb_itch_frame_assembler;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_last;
  logic        o_ready;
  logic [31:0] o_reg_1, o_reg_2, o_reg_3;
  logic        o_valid;
  logic [15:0] o_msg_count, o_drop_count;

  logic        n_ready, n_valid;
  logic [31:0] n_reg_1, n_reg_2, n_reg_3;
  logic [3:0]  n_msg_count, n_drop_count;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int ready_err = 0;
  logic [31:0] cap_1 = '0, cap_2 = '0, cap_3 = '0;

  always #5 clk = ~clk;

  itch_frame_assembler #(.REG_WIDTH(32), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_reg_1(o_reg_1), .o_reg_2(o_reg_2), .o_reg_3(o_reg_3),
    .o_valid(o_valid), .o_msg_count(o_msg_count), .o_drop_count(o_drop_count)
  );

  itch_frame_assembler #(.REG_WIDTH(32), .CNT_WIDTH(4)) dut_narrow (
    .i_clk(clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(n_ready), .o_reg_1(n_reg_1), .o_reg_2(n_reg_2), .o_reg_3(n_reg_3),
    .o_valid(n_valid), .o_msg_count(n_msg_count), .o_drop_count(n_drop_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // o_valid pulses and o_ready must be exact complements outside reset.
  always @(negedge clk) begin
    if (o_valid) begin
      valid_cnt++;
      cap_1 = o_reg_1;
      cap_2 = o_reg_2;
      cap_3 = o_reg_3;
    end
    if (!i_reset && (o_ready == o_valid)) ready_err++;
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    int guard;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    guard   = 0;
    while (!o_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 64'(guard), 64'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
  endtask

  task automatic send_msg(input logic [7:0] base);
    for (int i = 0; i < 12; i++) send_byte(base + 8'(i), i == 11);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_reg_1", o_reg_1, 0);
    check("rst_valid", o_valid, 0);
    check("rst_msg_count", o_msg_count, 0);
    check("rst_ready_in_reset", o_ready, 0);
    i_reset = 1'b0;
    #1 check("ready_after_reset", o_ready, 1);

    // Message 0x01..0x0C back-to-back, then exact latency and one-cycle strobe.
    send_msg(8'h01);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    check("latency_valid_high", o_valid, 1);
    check("emit_ready_low", o_ready, 0);
    @(negedge clk);
    check("valid_one_cycle", o_valid, 0);
    check("m1_reg_1", o_reg_1, 32'h01020304);
    check("m1_reg_2", o_reg_2, 32'h05060708);
    check("m1_reg_3", o_reg_3, 32'h090A0B0C);
    check("m1_msg_count", o_msg_count, 1);
    check("m1_valid_pulses", valid_cnt, 1);

    // Same message with i_valid toggled every cycle.
    for (int i = 0; i < 12; i++) begin
      send_byte(8'h01 + 8'(i), i == 11);
      idle(1);
    end
    idle(2);
    check("toggle_reg_1", cap_1, 32'h01020304);
    check("toggle_reg_2", cap_2, 32'h05060708);
    check("toggle_reg_3", cap_3, 32'h090A0B0C);
    check("toggle_msg_count", o_msg_count, 2);

    // Two messages back-to-back; the 13th byte must wait out the emit cycle.
    send_msg(8'h01);
    send_msg(8'h01);
    idle(3);
    check("b2b_valid_pulses", valid_cnt, 4);
    check("b2b_reg_3", o_reg_3, 32'h090A0B0C);
    check("b2b_msg_count", o_msg_count, 4);
    check("ready_complement", ready_err, 0);

    // Reset after 7 bytes; a byte presented with reset is lost.
    for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i), 1'b0);
    @(negedge clk);
    i_reset = 1'b1;
    i_data  = 8'hFF;
    @(negedge clk);
    check("mid_rst_reg_1", o_reg_1, 0);
    check("mid_rst_reg_3", o_reg_3, 0);
    check("mid_rst_msg_count", o_msg_count, 0);
    check("mid_rst_drop_count", o_drop_count, 0);
    i_reset = 1'b0;
    i_valid = 1'b0;
    send_msg(8'h21);
    idle(2);
    check("fresh_reg_1", o_reg_1, 32'h21222324);
    check("fresh_reg_2", o_reg_2, 32'h25262728);
    check("fresh_reg_3", o_reg_3, 32'h292A2B2C);
    check("fresh_msg_count", o_msg_count, 1);
    check("fresh_drop_count", o_drop_count, 0);

`ifdef FRAME_CHECK_EN
    // Runt of 5 bytes, then a good message.
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) send_byte(8'h30 + 8'(i), i == 4);
    send_msg(8'hA0);
    idle(2);
    check("runt_drop_count", o_drop_count, 1);
    check("runt_reg_1", o_reg_1, 32'hA0A1A2A3);
    check("runt_reg_3", o_reg_3, 32'hA8A9AAAB);
    check("runt_valid_pulses", valid_cnt - v0, 1);

    // Oversize 15-byte frame, then a good message.
    v0 = valid_cnt;
    for (int i = 0; i < 15; i++) send_byte(8'h50 + 8'(i), i == 14);
    idle(2);
    check("over_no_valid", valid_cnt - v0, 0);
    check("over_drop_count", o_drop_count, 2);
    check("over_reg_1_kept", o_reg_1, 32'hA0A1A2A3);
    send_msg(8'hB0);
    idle(2);
    check("over_next_reg_1", o_reg_1, 32'hB0B1B2B3);
    check("over_next_reg_3", o_reg_3, 32'hB8B9BABB);
    check("over_next_valid", valid_cnt - v0, 1);
`endif

    // Message counter wrap on the 4-bit instance.
    do_reset();
    for (int m = 0; m < 15; m++) send_msg(8'h10);
    idle(2);
    check("wrap_narrow_15", n_msg_count, 15);
    check("wrap_wide_15", o_msg_count, 15);
    send_msg(8'h10);
    idle(2);
    check("wrap_narrow_0", n_msg_count, 0);
    check("wrap_wide_16", o_msg_count, 16);
    check("wrap_drop_zero", o_drop_count, 0);

`ifdef FRAME_CHECK_EN
    // Drop counter saturation: 17 one-byte runts.
    do_reset();
    for (int r = 0; r < 15; r++) send_byte(8'hEE, 1'b1);
    idle(1);
    check("sat_narrow_15", n_drop_count, 15);
    send_byte(8'hEE, 1'b1);
    send_byte(8'hEE, 1'b1);
    idle(1);
    check("sat_narrow_held", n_drop_count, 15);
    check("sat_wide_17", o_drop_count, 17);
`endif

    check("ready_complement_final", ready_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
